// File: rtl/cmp_pkg.sv
// cmp_pkg -- shared types for the compare stream tracker.
//   state_t   : frame-tracking FSM states (IDLE, IN_FRAME).
//   cmp_res_t : one-hot compare result, bit order {lt, gt, eq}.
//               CMP_NONE is the all-zero value that is held in reset.
package cmp_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    CMP_NONE = 3'b000,
    CMP_EQ   = 3'b001,
    CMP_GT   = 3'b010,
    CMP_LT   = 3'b100
  } cmp_res_t;

endpackage

// File: rtl/cmp_core.sv
// cmp_core -- combinational compare of two operands, with max/min select.
// Ports:
//   a, b        : operands (WIDTH bits)
//   signed_mode : 1 = two's-complement compare, 0 = unsigned
//   res         : one-hot {lt, gt, eq} result of a versus b
//   max_v/min_v : larger / smaller operand under the selected mode
module cmp_core
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output cmp_res_t         res,
  output logic [WIDTH-1:0] max_v,
  output logic [WIDTH-1:0] min_v
);

  // Flipping the sign bit maps two's-complement order onto unsigned order,
  // so one unsigned magnitude compare serves both modes.
  logic [WIDTH-1:0] sign_flip;
  logic [WIDTH-1:0] a_k;
  logic [WIDTH-1:0] b_k;

  assign sign_flip = {signed_mode, {(WIDTH-1){1'b0}}};
  assign a_k       = a ^ sign_flip;
  assign b_k       = b ^ sign_flip;

  always_comb begin
    res = CMP_EQ;
    if (a_k > b_k) begin
      res = CMP_GT;
    end else if (a_k < b_k) begin
      res = CMP_LT;
    end
  end

  assign max_v = (res == CMP_LT) ? b : a;
  assign min_v = (res == CMP_LT) ? a : b;

endmodule

// File: rtl/cmp_stream_tracker.sv
// cmp_stream_tracker -- per-beat compare of x/y plus frame-running max/min
// and a saturating beat counter, behind a single output register.
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   in_valid/in_ready      : operand beat handshake
//   x, y, signed_mode      : operands and per-beat compare mode
//   first, last            : frame delimiters, sampled with the beat
//   out_valid/out_ready    : result handshake
//   eq, gt, lt             : registered per-beat compare (exactly one set)
//   max_xy, min_xy         : registered per-beat extremes
//   run_max, run_min       : frame-running extremes including this beat
//   beat_cnt               : beats in the frame so far (saturating)
//   frame_done             : result belongs to a beat with last=1
//   dbg_state              : FSM state (0 = IDLE, 1 = IN_FRAME)
//
// Handshake: a beat moves when in_valid && in_ready; a result moves when
// out_valid && out_ready. in_ready = !out_valid || out_ready, so the single
// output register refills on the same edge it drains and results hold
// steady while out_valid && !out_ready.
module cmp_stream_tracker
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             signed_mode,
  input  logic             first,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic [WIDTH-1:0] max_xy,
  output logic [WIDTH-1:0] min_xy,
  output logic [WIDTH-1:0] run_max,
  output logic [WIDTH-1:0] run_min,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             frame_done,
  output logic             dbg_state
);

  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  state_t           state;
  state_t           state_next;
  cmp_res_t         res_q;
  cmp_res_t         beat_res;
  logic [WIDTH-1:0] beat_max;
  logic [WIDTH-1:0] beat_min;
  logic [WIDTH-1:0] hi_max;
  logic [WIDTH-1:0] lo_min;
  logic             accept;
  logic             start_frame;

  // Only the max side of the high-tracking compare and the min side of the
  // low-tracking compare matter; the rest is left dangling on purpose.
  cmp_res_t         unused_hi_res;
  cmp_res_t         unused_lo_res;
  logic [WIDTH-1:0] unused_hi_min;
  logic [WIDTH-1:0] unused_lo_max;

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  // A beat opens a new frame when flagged first, or when no frame is open.
  assign start_frame = first || (state == IDLE);
  assign {lt, gt, eq} = res_q;
  assign dbg_state = state;

  // Per-beat compare of the incoming operands.
  cmp_core #(.WIDTH(WIDTH)) u_beat (
    .a           (x),
    .b           (y),
    .signed_mode (signed_mode),
    .res         (beat_res),
    .max_v       (beat_max),
    .min_v       (beat_min)
  );

  // Running compare: fold this beat's extremes into the frame extremes.
  cmp_core #(.WIDTH(WIDTH)) u_run_hi (
    .a           (beat_max),
    .b           (run_max),
    .signed_mode (signed_mode),
    .res         (unused_hi_res),
    .max_v       (hi_max),
    .min_v       (unused_hi_min)
  );

  cmp_core #(.WIDTH(WIDTH)) u_run_lo (
    .a           (beat_min),
    .b           (run_min),
    .signed_mode (signed_mode),
    .res         (unused_lo_res),
    .max_v       (unused_lo_max),
    .min_v       (lo_min)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: only an accepted beat moves it.
  always_comb begin
    state_next = state;
    if (accept) begin
      state_next = last ? IDLE : IN_FRAME;
    end
  end

  // Output register and running frame state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      res_q      <= CMP_NONE;
      max_xy     <= '0;
      min_xy     <= '0;
      run_max    <= '0;
      run_min    <= '0;
      beat_cnt   <= '0;
      frame_done <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      res_q      <= beat_res;
      max_xy     <= beat_max;
      min_xy     <= beat_min;
      frame_done <= last;
      if (start_frame) begin
        run_max  <= beat_max;
        run_min  <= beat_min;
        beat_cnt <= CNT_W'(1);
      end else begin
        run_max  <= hi_max;
        run_min  <= lo_min;
        if (beat_cnt != CNT_SAT) begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end else if (out_ready) begin
      // Result consumed with nothing new behind it; the data registers keep
      // their values because the running extremes carry into the next beat.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cmp_stream_tracker.sv
// tb_cmp_stream_tracker -- directed bench for cmp_stream_tracker (WIDTH=8).
// A second instance with CNT_W=2 shares all inputs to exercise counter
// saturation.
module tb_cmp_stream_tracker;

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic       sm;
    logic       f;
    logic       l;
    logic [2:0] e_res;   // {lt, gt, eq}
    logic [7:0] e_max;
    logic [7:0] e_min;
    logic [7:0] e_rmax;
    logic [7:0] e_rmin;
    logic [7:0] e_cnt;
    logic       e_done;
  } vec_t;

  localparam logic [2:0] R_EQ = 3'b001;
  localparam logic [2:0] R_GT = 3'b010;
  localparam logic [2:0] R_LT = 3'b100;

  // ---------------- clock / reset / signals ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready, in_ready_2;
  logic [7:0] x, y;
  logic       signed_mode, first, last;
  logic       out_valid, out_valid_2;
  logic       out_ready;
  logic       eq, gt, lt, eq_2, gt_2, lt_2;
  logic [7:0] max_xy, min_xy, run_max, run_min;
  logic [7:0] max_xy_2, min_xy_2, run_max_2, run_min_2;
  logic [7:0] beat_cnt;
  logic [1:0] beat_cnt_2;
  logic       frame_done, frame_done_2;
  logic       dbg_state, dbg_state_2;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  cmp_stream_tracker #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .signed_mode(signed_mode), .first(first), .last(last),
    .out_valid(out_valid), .out_ready(out_ready),
    .eq(eq), .gt(gt), .lt(lt), .max_xy(max_xy), .min_xy(min_xy),
    .run_max(run_max), .run_min(run_min), .beat_cnt(beat_cnt),
    .frame_done(frame_done), .dbg_state(dbg_state)
  );

  cmp_stream_tracker #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_2),
    .x(x), .y(y), .signed_mode(signed_mode), .first(first), .last(last),
    .out_valid(out_valid_2), .out_ready(out_ready),
    .eq(eq_2), .gt(gt_2), .lt(lt_2), .max_xy(max_xy_2), .min_xy(min_xy_2),
    .run_max(run_max_2), .run_min(run_min_2), .beat_cnt(beat_cnt_2),
    .frame_done(frame_done_2), .dbg_state(dbg_state_2)
  );

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    check({tag, " out_valid"},  32'(out_valid), 32'd1);
    check({tag, " res"},        32'({lt, gt, eq}), 32'(v.e_res));
    check({tag, " max_xy"},     32'(max_xy), 32'(v.e_max));
    check({tag, " min_xy"},     32'(min_xy), 32'(v.e_min));
    check({tag, " run_max"},    32'(run_max), 32'(v.e_rmax));
    check({tag, " run_min"},    32'(run_min), 32'(v.e_rmin));
    check({tag, " beat_cnt"},   32'(beat_cnt), 32'(v.e_cnt));
    check({tag, " frame_done"}, 32'(frame_done), 32'(v.e_done));
    check({tag, " state"},      32'(dbg_state), 32'(!v.l));
  endtask

  // ---------------- driver ----------------
  // Offers one beat at edge+1 and leaves the bench at edge+1 after it is
  // taken; callers keep out_ready high so in_ready is 1 when this is used.
  task automatic apply_beat(input logic [7:0] ax, input logic [7:0] ay,
                            input logic asm, input logic af, input logic al);
    x = ax; y = ay; signed_mode = asm; first = af; last = al;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test ----------------
  vec_t vecs[9];

  initial begin
    vecs[0] = '{8'h80, 8'h7F, 1'b0, 1'b1, 1'b1, R_GT, 8'h80, 8'h7F, 8'h80, 8'h7F, 8'd1, 1'b1};
    vecs[1] = '{8'h80, 8'h7F, 1'b1, 1'b1, 1'b1, R_LT, 8'h7F, 8'h80, 8'h7F, 8'h80, 8'd1, 1'b1};
    vecs[2] = '{8'd3,  8'd9,  1'b0, 1'b1, 1'b0, R_LT, 8'd9,  8'd3,  8'd9,  8'd3,  8'd1, 1'b0};
    vecs[3] = '{8'd12, 8'd1,  1'b0, 1'b0, 1'b0, R_GT, 8'd12, 8'd1,  8'd12, 8'd1,  8'd2, 1'b0};
    vecs[4] = '{8'd5,  8'd5,  1'b0, 1'b0, 1'b1, R_EQ, 8'd5,  8'd5,  8'd12, 8'd1,  8'd3, 1'b1};
    // IDLE without first still opens a frame; signed running min picks 0xFF.
    vecs[5] = '{8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, R_LT, 8'h01, 8'hFF, 8'h01, 8'hFF, 8'd1, 1'b0};
    vecs[6] = '{8'h02, 8'h7F, 1'b1, 1'b0, 1'b0, R_LT, 8'h7F, 8'h02, 8'h7F, 8'hFF, 8'd2, 1'b0};
    // first mid-frame abandons the open frame and restarts it.
    vecs[7] = '{8'h10, 8'h20, 1'b0, 1'b1, 1'b0, R_LT, 8'h20, 8'h10, 8'h20, 8'h10, 8'd1, 1'b0};
    vecs[8] = '{8'h20, 8'h10, 1'b0, 1'b0, 1'b1, R_GT, 8'h20, 8'h10, 8'h20, 8'h10, 8'd2, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    x = '0; y = '0; signed_mode = 1'b0; first = 1'b0; last = 1'b0;
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset res",       32'({lt, gt, eq}), 32'd0);
    check("reset max/min",   32'({max_xy, min_xy}), 32'd0);
    check("reset run",       32'({run_max, run_min}), 32'd0);
    check("reset cnt/done",  32'({beat_cnt, frame_done}), 32'd0);
    check("reset state",     32'(dbg_state), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);

    // Table-driven beats with continuous out_ready.
    for (int i = 0; i < 9; i++) begin
      apply_beat(vecs[i].x, vecs[i].y, vecs[i].sm, vecs[i].f, vecs[i].l);
      check_vec($sformatf("vec%0d", i), vecs[i]);
    end
    @(posedge clk); #1;
    check("drain out_valid", 32'(out_valid), 32'd0);

    // Backpressure: beat A accepted, beat B held off for three cycles.
    out_ready = 1'b0;
    apply_beat(8'h11, 8'h22, 1'b0, 1'b1, 1'b0);
    check("bp A out_valid", 32'(out_valid), 32'd1);
    check("bp A max_xy",    32'(max_xy), 32'h22);
    x = 8'h33; y = 8'h30; signed_mode = 1'b0; first = 1'b0; last = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp hold%0d in_ready", i), 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      check($sformatf("bp hold%0d data", i),
            32'({max_xy, min_xy, beat_cnt}), {8'h0, 8'h22, 8'h11, 8'd1});
      check($sformatf("bp hold%0d valid", i), 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("bp release in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_vec("bp B", '{8'h33, 8'h30, 1'b0, 1'b0, 1'b1, R_GT, 8'h33, 8'h30,
                        8'h33, 8'h11, 8'd2, 1'b1});
    @(posedge clk); #1;
    check("bp no dup valid", 32'(out_valid), 32'd0);
    check("bp no dup cnt",   32'(beat_cnt), 32'd2);

    // Reset between beats 2 and 3 of a frame.
    apply_beat(8'd3, 8'd9, 1'b0, 1'b1, 1'b0);
    apply_beat(8'd12, 8'd1, 1'b0, 1'b0, 1'b0);
    check("pre-rst cnt", 32'(beat_cnt), 32'd2);
    rst = 1'b1;
    #1;
    check("async rst valid",  32'(out_valid), 32'd0);
    check("async rst data",   32'({max_xy, min_xy, run_max, run_min}), 32'd0);
    check("async rst flags",  32'({lt, gt, eq, frame_done, beat_cnt}), 32'd0);
    check("async rst state",  32'(dbg_state), 32'd0);
    #1;
    rst = 1'b0;
    #1;
    check("post-rst in_ready", 32'(in_ready), 32'd1);
    apply_beat(8'd5, 8'd5, 1'b0, 1'b0, 1'b1);
    check_vec("post-rst beat", '{8'd5, 8'd5, 1'b0, 1'b0, 1'b1, R_EQ, 8'd5, 8'd5,
                                 8'd5, 8'd5, 8'd1, 1'b1});

    // Five-beat frame: CNT_W=2 instance saturates at 3.
    for (int i = 0; i < 5; i++) begin
      apply_beat(8'(i + 1), 8'd0, 1'b0, i == 0, i == 4);
      check($sformatf("sat beat%0d cnt2", i), 32'(beat_cnt_2), (i + 1 > 3) ? 32'd3 : 32'(i + 1));
      check($sformatf("sat beat%0d cnt8", i), 32'(beat_cnt), 32'(i + 1));
      check($sformatf("sat beat%0d rmax2", i), 32'(run_max_2), 32'(i + 1));
      check($sformatf("sat beat%0d done2", i), 32'(frame_done_2), 32'(i == 4));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
